// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: 32-bit word stream in, padded 512-bit blocks out.
// Optional SHA_PAD_ABORT_EN adds in_abort to drop a message mid-flight.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
`ifdef SHA_PAD_ABORT_EN
  input  logic         in_abort,
`endif
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic {S_FILL, S_SEND} state_t;

  state_t           r_state, w_state_nx;
  logic [511:0]     r_blk, w_blk_nx;
  logic [3:0]       r_widx, w_widx_nx;
  logic [LEN_W-1:0] r_len, w_len_nx, w_len_add;
  logic             r_pad_pend, w_pad_pend_nx;
  logic             r_owe80, w_owe80_nx;
  logic             r_first_pend, w_first_pend_nx;
  logic             r_first, w_first_nx;
  logic             r_last, w_last_nx;
  logic             r_in_ready, w_in_ready_nx;
  logic             r_blk_valid, w_blk_valid_nx;
  logic             w_abort;
  logic [2:0]       w_nb;
  logic [6:0]       w_bcnt;
  logic [31:0]      w_word;
  logic [63:0]      w_len64, w_rlen64;

`ifdef SHA_PAD_ABORT_EN
  assign w_abort = in_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;
  assign blk_data  = r_blk;
  assign blk_first = r_first;
  assign blk_last  = r_last;

  assign w_nb      = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign w_bcnt    = {1'b0, r_widx, 2'b00} + 7'(w_nb);
  assign w_len_add = r_len + (in_last ? LEN_W'({w_nb, 3'b000})
                                      : LEN_W'(32));
  assign w_len64   = 64'(w_len_add);
  assign w_rlen64  = 64'(r_len);

  // Keep the valid bytes of the final word and drop 0x80 right after them
  always_comb begin
    case (w_nb)
      3'd0:    w_word = 32'h8000_0000;
      3'd1:    w_word = {in_data[31:24], 24'h80_0000};
      3'd2:    w_word = {in_data[31:16], 16'h8000};
      3'd3:    w_word = {in_data[31:8], 8'h80};
      default: w_word = in_data;
    endcase
  end

  always_comb begin
    w_state_nx      = r_state;
    w_blk_nx        = r_blk;
    w_widx_nx       = r_widx;
    w_len_nx        = r_len;
    w_pad_pend_nx   = r_pad_pend;
    w_owe80_nx      = r_owe80;
    w_first_pend_nx = r_first_pend;
    w_first_nx      = r_first;
    w_last_nx       = r_last;
    w_in_ready_nx   = r_in_ready;
    w_blk_valid_nx  = r_blk_valid;
    unique case (r_state)
      S_FILL: begin
        w_in_ready_nx = 1'b1;
        if (w_abort) begin
          w_widx_nx       = '0;
          w_len_nx        = '0;
          w_first_pend_nx = 1'b1;
          w_pad_pend_nx   = 1'b0;
          w_owe80_nx      = 1'b0;
        end else if (in_valid && r_in_ready) begin
          w_len_nx  = w_len_add;
          w_widx_nx = r_widx + 4'd1;
          if (!in_last) begin
            w_blk_nx[{r_widx, 5'd0} +: 32] = in_data;
          end else begin
            w_widx_nx = '0;
            for (int j = 0; j < 16; j++) begin
              if (j == int'(r_widx))
                w_blk_nx[32*j +: 32] = w_word;
              else if (j > int'(r_widx))
                w_blk_nx[32*j +: 32] =
                  (j == int'(r_widx) + 1 && w_nb == 3'd4) ?
                  32'h8000_0000 : 32'h0;
            end
          end
          if (in_last || r_widx == 4'd15) begin
            w_state_nx      = S_SEND;
            w_in_ready_nx   = 1'b0;
            w_blk_valid_nx  = 1'b1;
            w_first_nx      = r_first_pend;
            w_first_pend_nx = 1'b0;
            w_last_nx       = 1'b0;
            w_pad_pend_nx   = 1'b0;
            w_owe80_nx      = 1'b0;
            if (in_last && w_bcnt <= 7'd55) begin
              w_blk_nx[479:448] = w_len64[63:32];
              w_blk_nx[511:480] = w_len64[31:0];
              w_last_nx         = 1'b1;
            end else if (in_last) begin
              w_pad_pend_nx = 1'b1;
              w_owe80_nx    = (w_bcnt == 7'd64);
            end
          end
        end
      end
      S_SEND: begin
        w_in_ready_nx  = 1'b0;
        w_blk_valid_nx = 1'b1;
        if (w_abort) begin
          w_state_nx      = S_FILL;
          w_blk_valid_nx  = 1'b0;
          w_in_ready_nx   = 1'b1;
          w_pad_pend_nx   = 1'b0;
          w_owe80_nx      = 1'b0;
          w_widx_nx       = '0;
          w_len_nx        = '0;
          w_first_pend_nx = 1'b1;
          w_first_nx      = 1'b0;
          w_last_nx       = 1'b0;
        end else if (blk_ready) begin
          if (r_pad_pend) begin
            w_blk_nx = {w_rlen64[31:0], w_rlen64[63:32], 416'h0,
                        (r_owe80 ? 32'h8000_0000 : 32'h0)};
            w_last_nx     = 1'b1;
            w_first_nx    = 1'b0;
            w_pad_pend_nx = 1'b0;
            w_owe80_nx    = 1'b0;
          end else begin
            w_state_nx     = S_FILL;
            w_blk_valid_nx = 1'b0;
            w_in_ready_nx  = 1'b1;
            if (r_last) begin
              w_len_nx        = '0;
              w_first_pend_nx = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_blk        <= '0;
      r_widx       <= '0;
      r_len        <= '0;
      r_pad_pend   <= 1'b0;
      r_owe80      <= 1'b0;
      r_first_pend <= 1'b1;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_blk_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_blk        <= w_blk_nx;
      r_widx       <= w_widx_nx;
      r_len        <= w_len_nx;
      r_pad_pend   <= w_pad_pend_nx;
      r_owe80      <= w_owe80_nx;
      r_first_pend <= w_first_pend_nx;
      r_first      <= w_first_nx;
      r_last       <= w_last_nx;
      r_in_ready   <= w_in_ready_nx;
      r_blk_valid  <= w_blk_valid_nx;
    end
  end

endmodule
